// File: rtl/coef_frame_loader.sv
// ---------------------------------------------------------------------------
// coef_frame_loader
// Packs a byte stream into 136-bit words for the NTT/INTT test wrapper.
// A frame is FRAME_WORDS words (64 coefficients + 1 seed). After the last
// word the loader pulses ntt_start, holds mode_out, and refuses input until
// the wrapper's done pulse (dvld) arrives.
//
// Optional build macro: LOADER_TIMEOUT_EN
//   When defined, a partial frame that sees no accepted byte for TIMEOUT
//   cycles is discarded and err is raised.
//
// Ports
//   clk         in   1    clock
//   rst         in   1    asynchronous active-low reset
//   byte_in     in   8    input byte
//   byte_vld    in   1    byte_in valid (transfer on byte_vld & byte_rdy)
//   byte_rdy    out  1    loader can accept a byte
//   mode_in     in   3    mode, sampled at the first byte of each frame
//   dvld        in   1    done pulse from the wrapper
//   word_out    out  136  assembled word (first byte in bits [135:128])
//   word_vld    out  1    one-cycle word strobe
//   ntt_start   out  1    one-cycle start pulse
//   mode_out    out  3    latched mode
//   frame_done  out  1    one-cycle pulse when dvld accepted in WAIT_DONE
//   err         out  1    sticky error flag
// ---------------------------------------------------------------------------
module coef_frame_loader #(
    parameter int          WORD_BYTES  = 17,
    parameter int          FRAME_WORDS = 65,
    parameter logic [19:0] TIMEOUT     = 20'hFFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              byte_in,
    input  logic                    byte_vld,
    output logic                    byte_rdy,
    input  logic [2:0]              mode_in,
    input  logic                    dvld,
    output logic [WORD_BYTES*8-1:0] word_out,
    output logic                    word_vld,
    output logic                    ntt_start,
    output logic [2:0]              mode_out,
    output logic                    frame_done,
    output logic                    err
);

    localparam int         W         = WORD_BYTES * 8;
    localparam logic [4:0] LAST_BYTE = 5'(WORD_BYTES - 1);
    localparam logic [6:0] LAST_WORD = 7'(FRAME_WORDS - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] FIRE      = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]   state_r;
    logic [4:0]   byte_cnt_r;
    logic [6:0]   word_cnt_r;
    logic [W-1:0] sh_r;
    logic [W-1:0] word_out_r;
    logic         byte_rdy_r;
    logic         word_vld_r;
    logic         ntt_start_r;
    logic [2:0]   mode_out_r;
    logic         frame_done_r;
    logic         err_r;

    logic         accept_s;
    logic         first_byte_s;
    logic         timeout_hit_s;

    assign accept_s     = byte_vld & byte_rdy_r & (state_r == LOAD);
    assign first_byte_s = (word_cnt_r == 7'd0) && (byte_cnt_r == 5'd0);

`ifdef LOADER_TIMEOUT_EN
    logic [19:0] idle_cnt_r;
    logic        frame_open_s;

    // Only a partially loaded frame in LOAD can time out.
    assign frame_open_s  = (state_r == LOAD) && !first_byte_s;
    assign timeout_hit_s = frame_open_s && !accept_s && (idle_cnt_r == TIMEOUT);

    // Idle counter: cleared by every accepted byte, runs while a frame is open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_r <= 20'd0;
        end else if (!frame_open_s || accept_s || timeout_hit_s) begin
            idle_cnt_r <= 20'd0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 20'd1;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Main FSM, byte packing and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            byte_cnt_r   <= 5'd0;
            word_cnt_r   <= 7'd0;
            sh_r         <= '0;
            word_out_r   <= '0;
            byte_rdy_r   <= 1'b0;
            word_vld_r   <= 1'b0;
            ntt_start_r  <= 1'b0;
            mode_out_r   <= 3'd0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            word_vld_r   <= 1'b0;
            ntt_start_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r    <= LOAD;
                    byte_rdy_r <= 1'b1;
                end
                LOAD: begin
                    if (accept_s) begin
                        sh_r <= {sh_r[W-9:0], byte_in};
                        if (first_byte_s) begin
                            mode_out_r <= mode_in;
                            err_r      <= 1'b0;
                        end
                        if (byte_cnt_r == LAST_BYTE) begin
                            word_out_r <= {sh_r[W-9:0], byte_in};
                            word_vld_r <= 1'b1;
                            byte_cnt_r <= 5'd0;
                            word_cnt_r <= word_cnt_r + 7'd1;
                            // Last word: stop accepting in the strobe cycle.
                            if (word_cnt_r == LAST_WORD) begin
                                state_r    <= FIRE;
                                byte_rdy_r <= 1'b0;
                            end
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 5'd1;
                        end
                    end else if (timeout_hit_s) begin
                        byte_cnt_r <= 5'd0;
                        word_cnt_r <= 7'd0;
                        err_r      <= 1'b1;
                    end
                end
                FIRE: begin
                    // One cycle after the last strobe so the wrapper's word counter has wrapped.
                    ntt_start_r <= 1'b1;
                    word_cnt_r  <= 7'd0;
                    state_r     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (dvld) begin
                        frame_done_r <= 1'b1;
                        state_r      <= LOAD;
                        byte_rdy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    byte_rdy_r <= 1'b0;
                end
            endcase
            // A done pulse outside WAIT_DONE is a protocol error; it wins over the first-byte clear.
            if (dvld && (state_r != WAIT_DONE)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign byte_rdy   = byte_rdy_r;
    assign word_out   = word_out_r;
    assign word_vld   = word_vld_r;
    assign ntt_start  = ntt_start_r;
    assign mode_out   = mode_out_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_coef_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_coef_frame_loader
// Scoreboard bench: the driver pushes the words each frame should produce
// (built from the byte list) into a queue; a monitor pops and compares on
// every word_vld and checks mode_out / start latency on every ntt_start.
// ---------------------------------------------------------------------------
module tb_coef_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   byte_in;
    logic         byte_vld;
    logic         byte_rdy;
    logic [2:0]   mode_in;
    logic         dvld;
    logic [135:0] word_out;
    logic         word_vld;
    logic         ntt_start;
    logic [2:0]   mode_out;
    logic         frame_done;
    logic         err;

    coef_frame_loader dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_vld   (byte_vld),
        .byte_rdy   (byte_rdy),
        .mode_in    (mode_in),
        .dvld       (dvld),
        .word_out   (word_out),
        .word_vld   (word_vld),
        .ntt_start  (ntt_start),
        .mode_out   (mode_out),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [135:0] exp_words[$];
    logic [7:0]   fr [0:1104];
    logic [2:0]   frame_mode = 3'd0;
    int           last_acc = 0;
    int           starts_seen = 0;
    int           frame_words = 0;
    int           last_wv = 0;
    bit           chk_spacing = 1'b0;
    bit           first_captured = 1'b0;
    logic [135:0] first_word = '0;

    task automatic check(input bit ok, input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every complete group of 17 bytes forms one word, first byte most significant.
    task automatic push_words(input int nbytes);
        logic [135:0] w;
        for (int k = 0; k < nbytes / 17; k++) begin
            w = '0;
            for (int b = 0; b < 17; b++) w = {w[127:0], fr[k*17+b]};
            exp_words.push_back(w);
        end
    endtask

    // Monitor: pops expected words and checks start timing and mode.
    always @(negedge clk) begin
        if (!rst) begin
            frame_words = 0;
        end else begin
            if (word_vld) begin
                if (exp_words.size() == 0) begin
                    check(1'b0, "unexpected_word_vld", word_out, '0);
                end else begin
                    logic [135:0] e;
                    e = exp_words.pop_front();
                    check(word_out == e, "word_out", word_out, e);
                end
                check(mode_out == frame_mode, "mode_out_at_word", 136'(mode_out), 136'(frame_mode));
                if (!first_captured) begin
                    first_word     = word_out;
                    first_captured = 1'b1;
                end
                if (chk_spacing && frame_words > 0)
                    check((cyc - last_wv) == 34, "word_vld_spacing", 136'(cyc - last_wv), 136'd34);
                last_wv = cyc;
                frame_words++;
            end
            if (ntt_start) begin
                starts_seen++;
                check(frame_words == 65, "words_per_frame", 136'(frame_words), 136'd65);
                check(cyc == last_acc + 2, "start_latency", 136'(cyc - last_acc), 136'd2);
                check(mode_out == frame_mode, "mode_out_at_start", 136'(mode_out), 136'(frame_mode));
                frame_words = 0;
            end
        end
    end

    // Drive n bytes from fr[]; gap_mode 0 = every cycle, 1 = every other cycle, 2 = random.
    task automatic send_bytes(input int n, input int gap_mode, input bit chk_err);
        int  idx = 0;
        int  budget = 0;
        bit  err_checked = 1'b0;
        while (idx < n && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (chk_err && idx == 1 && !err_checked) begin
                check(err == 1'b0, "err_cleared_by_first_byte", 136'(err), 136'd0);
                err_checked = 1'b1;
            end
            mode_in = 3'($urandom_range(0, 7));
            case (gap_mode)
                0:       byte_vld = 1'b1;
                1:       byte_vld = budget[0];
                default: byte_vld = 1'($urandom_range(0, 1));
            endcase
            byte_in = fr[idx];
            if (byte_vld && byte_rdy) begin
                if (idx == 0) frame_mode = mode_in;
                last_acc = cyc;
                idx++;
            end
        end
        if (idx < n) check(1'b0, "send_timeout", 136'(idx), 136'(n));
    endtask

    task automatic wait_start(input int target);
        int b = 0;
        while (starts_seen < target && b < 100) begin
            @(negedge clk);
            b++;
        end
        check(starts_seen == target, "ntt_start_count", 136'(starts_seen), 136'(target));
    endtask

    // Wait for the start, optionally keep offering bytes, then return the done pulse.
    task automatic finish_frame(input int target, input int hold);
        @(negedge clk);
        byte_vld = (hold > 0);
        wait_start(target);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check(byte_rdy == 1'b0, "byte_rdy_low_wait_done", 136'(byte_rdy), 136'd0);
        end
        byte_vld = 1'b0;
        dvld = 1'b1;
        @(negedge clk);
        dvld = 1'b0;
        check(frame_done == 1'b1, "frame_done_pulse", 136'(frame_done), 136'd1);
        check(byte_rdy == 1'b1, "byte_rdy_after_done", 136'(byte_rdy), 136'd1);
        @(negedge clk);
        check(frame_done == 1'b0, "frame_done_one_cycle", 136'(frame_done), 136'd0);
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) fr[k] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        rst = 1'b0; byte_in = 8'd0; byte_vld = 1'b0; mode_in = 3'd0; dvld = 1'b0;
        repeat (3) @(negedge clk);
        check({byte_rdy, word_vld, ntt_start, frame_done, err} == 5'd0, "reset_flags",
              136'({byte_rdy, word_vld, ntt_start, frame_done, err}), 136'd0);
        check(word_out == '0 && mode_out == 3'd0, "reset_word_mode", word_out, '0);
        rst = 1'b1;
        @(negedge clk);
        check(byte_rdy == 1'b1, "byte_rdy_after_idle", 136'(byte_rdy), 136'd1);

        // Counting frame, back-to-back, then a 100-cycle hold against WAIT_DONE.
        for (int k = 0; k < 1105; k++) fr[k] = 8'(k);
        push_words(1105);
        send_bytes(1105, 0, 1'b1);
        finish_frame(1, 100);
        check(first_word == 136'h000102030405060708090a0b0c0d0e0f10, "first_word", first_word,
              136'h000102030405060708090a0b0c0d0e0f10);

        // dvld while loading is an error but changes nothing else.
        dvld = 1'b1;
        @(negedge clk);
        dvld = 1'b0;
        check(err == 1'b1, "err_dvld_in_load", 136'(err), 136'd1);
        check(byte_rdy == 1'b1 && frame_done == 1'b0, "no_state_change", 136'({byte_rdy, frame_done}), 136'd2);

        // Same frame with byte_vld toggling: identical words every 34 cycles.
        push_words(1105);
        chk_spacing = 1'b1;
        send_bytes(1105, 1, 1'b1);
        chk_spacing = 1'b0;
        finish_frame(2, 0);

        // Random frame with dvld arriving while the FSM is in FIRE.
        fill_random(1105);
        push_words(1105);
        send_bytes(1105, 2, 1'b0);
        @(negedge clk);
        byte_vld = 1'b0;
        dvld = 1'b1;
        @(negedge clk);
        dvld = 1'b0;
        check(err == 1'b1, "err_dvld_in_fire", 136'(err), 136'd1);
        repeat (3) @(negedge clk);
        check(frame_done == 1'b0 && byte_rdy == 1'b0, "still_waiting", 136'({frame_done, byte_rdy}), 136'd0);
        finish_frame(3, 0);

        // Reset after 500 bytes: complete words come out, then everything is discarded.
        fill_random(500);
        push_words(500);
        send_bytes(500, 0, 1'b1);
        @(negedge clk);
        byte_vld = 1'b0;
        repeat (3) @(negedge clk);
        check(exp_words.size() == 0, "partial_words_drained", 136'(exp_words.size()), 136'd0);
        rst = 1'b0;
        @(negedge clk);
        check({byte_rdy, word_vld, ntt_start, err} == 4'd0 && word_out == '0 && mode_out == 3'd0,
              "mid_frame_reset", 136'({byte_rdy, word_vld, ntt_start, err}), 136'd0);
        rst = 1'b1;
        check(starts_seen == 3, "no_start_from_partial", 136'(starts_seen), 136'd3);
        fill_random(1105);
        push_words(1105);
        send_bytes(1105, 2, 1'b0);
        finish_frame(4, 0);

        check(exp_words.size() == 0, "scoreboard_empty", 136'(exp_words.size()), 136'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
